// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM encoding and address-field geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_FILL      = 2'd3
    } cache_state_t;

    localparam int TAG_W = 3;
    localparam int IDX_W = 3;
    localparam int OFF_W = 2;

    // Byte address layout: {tag, index, offset}
    localparam int OFF_LSB = 0;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

endpackage

// File: rtl/cache_store.sv
// Tag/valid/dirty/data arrays with combinational hit detect and byte readout.
// Latency: lookup is combinational; byte write and line fill land at the next posedge.
// Backpressure: none; the controlling FSM decides when writes are enabled.
module cache_store
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [IDX_W-1:0]         index,
    input  logic [TAG_W-1:0]         tag,
    input  logic [OFF_W-1:0]         offset,
    input  logic                     byte_we,
    input  logic [7:0]               byte_wdata,
    input  logic                     fill_we,
    input  logic [8*BLOCK_BYTES-1:0] fill_data,
    output logic                     hit,
    output logic [7:0]               rd_byte,
    output logic                     victim_dirty,
    output logic [TAG_W-1:0]         victim_tag,
    output logic [8*BLOCK_BYTES-1:0] victim_data
);

    logic [NUM_BLOCKS-1:0]    valid_q;
    logic [NUM_BLOCKS-1:0]    dirty_q;
    logic [TAG_W-1:0]         tag_q  [NUM_BLOCKS];
    logic [8*BLOCK_BYTES-1:0] data_q [NUM_BLOCKS];

    assign victim_tag   = tag_q[index];
    assign victim_data  = data_q[index];
    assign victim_dirty = valid_q[index] & dirty_q[index];
    assign hit          = valid_q[index] && (tag_q[index] == tag);
    assign rd_byte      = victim_data[{offset, 3'b000} +: 8];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[index]  <= tag;
            data_q[index] <= fill_data;
        end else if (byte_we) begin
            data_q[index][{offset, 3'b000} +: 8] <= byte_wdata;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate byte cache in front of a block-wide memory.
// Latency: read hit 0 cycles, write hit 1 posedge; misses add writeback/fetch/fill cycles.
// Backpressure: BUSYWAIT stalls the CPU on a miss; MEM_BUSYWAIT stretches each memory phase.
module data_cache
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [7:0]               ADDRESS,
    input  logic [7:0]               WRITEDATA,
    output logic [7:0]               READDATA,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic                     MEM_WRITE,
    output logic [TAG_W+IDX_W-1:0]   MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0] MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0] MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    cache_state_t             state_q, state_d;
    logic                     first_q;
    logic [8*BLOCK_BYTES-1:0] stage_q;

    logic [TAG_W-1:0]         addr_tag;
    logic [IDX_W-1:0]         addr_idx;
    logic [OFF_W-1:0]         addr_off;
    logic                     req, is_store, mem_done;
    logic                     hit, victim_dirty, byte_we, fill_we;
    logic [7:0]               rd_byte;
    logic [TAG_W-1:0]         victim_tag;
    logic [8*BLOCK_BYTES-1:0] victim_data;

    assign addr_tag = ADDRESS[TAG_LSB +: TAG_W];
    assign addr_idx = ADDRESS[IDX_LSB +: IDX_W];
    assign addr_off = ADDRESS[OFF_LSB +: OFF_W];
    assign req      = READ | WRITE;
    assign is_store = WRITE & ~READ;
    // The entry cycle of a memory phase never completes it.
    assign mem_done = ~first_q & ~MEM_BUSYWAIT;

    cache_store #(
        .NUM_BLOCKS  (NUM_BLOCKS),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_store (
        .CLK          (CLK),
        .RESET        (RESET),
        .index        (addr_idx),
        .tag          (addr_tag),
        .offset       (addr_off),
        .byte_we      (byte_we),
        .byte_wdata   (WRITEDATA),
        .fill_we      (fill_we),
        .fill_data    (stage_q),
        .hit          (hit),
        .rd_byte      (rd_byte),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            if (state_q == S_FETCH && mem_done) begin
                stage_q <= MEM_READDATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req && !hit) state_d = victim_dirty ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: if (mem_done) state_d = S_FETCH;
            S_FETCH:     if (mem_done) state_d = S_FILL;
            S_FILL:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even if a request is present.
    always_comb begin
        BUSYWAIT      = 1'b0;
        READDATA      = 8'h00;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        byte_we       = 1'b0;
        fill_we       = 1'b0;
        if (RESET) begin
            case (state_q)
                S_IDLE: begin
                    BUSYWAIT = req & ~hit;
                    byte_we  = is_store & hit;
                    if (READ && hit) READDATA = rd_byte;
                end
                S_WRITEBACK: begin
                    BUSYWAIT      = 1'b1;
                    MEM_WRITE     = 1'b1;
                    MEM_ADDRESS   = {victim_tag, addr_idx};
                    MEM_WRITEDATA = victim_data;
                end
                S_FETCH: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = {addr_tag, addr_idx};
                end
                S_FILL: begin
                    BUSYWAIT = 1'b1;
                    fill_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 256-byte `data_memory`. On a load, it supplies the byte that the writeback mux routes into the register-file `IN` port. It is the producing end of the register-file write path. It holds the CPU on a miss with `BUSYWAIT` while it writes back a dirty block and/or fetches a 4-byte block over the memory handshake.

## Interface
- `NUM_BLOCKS`, 8: cache lines; index width = log2.
- `BLOCK_BYTES`, 4: bytes per line; offset width = log2; memory word = 8*BLOCK_BYTES.
- `CLK`  in  1  single clock; all state changes on posedge.
- `RESET`  in  1  reset; asynchronous, active-low.
- `READ`  in  1  CPU load request; held stable while `BUSYWAIT`=1.
- `WRITE`  in  1  CPU store request; mutually exclusive with `READ`.
- `ADDRESS`  in  8  byte address, split as tag[7:5], index[4:2], offset[1:0].
- `WRITEDATA`  in  8  store byte.
- `READDATA`  out  8  load byte (to register-file `IN` via writeback mux).
- `BUSYWAIT`  out  1  CPU stall.
- `MEM_READ`  out  1  block fetch request.
- `MEM_WRITE`  out  1  block writeback request.
- `MEM_ADDRESS`  out  6  block address {tag,index}.
- `MEM_WRITEDATA`  out  32  victim block, byte0 in [7:0].
- `MEM_READDATA`  in  32  fetched block, byte0 in [7:0].
- `MEM_BUSYWAIT`  in  1  memory busy.

## Operation
- Per line: `valid`, `dirty`, 3-bit tag, 4 data bytes.
- Hit = `valid[index]` && tag match.
- FSM states: IDLE, WRITEBACK, FETCH, FILL.
- IDLE:
  - Read hit: `READDATA` = the addressed byte, combinational. `BUSYWAIT`=0.
  - Write hit: byte written and `dirty` set at the next posedge. `BUSYWAIT`=0.
  - Miss with victim `dirty`: go to WRITEBACK. Otherwise go to FETCH.
  - `BUSYWAIT`=1 combinationally in the miss cycle.
- WRITEBACK:
  - `MEM_WRITE`=1, `MEM_ADDRESS`={victim tag,index}, `MEM_WRITEDATA`=victim block.
  - Go to FETCH on exit.
- FETCH:
  - `MEM_READ`=1, `MEM_ADDRESS`={ADDRESS[7:2]}.
  - Capture `MEM_READDATA` into a staging register on exit.
- FILL:
  - Write the staged block, set `valid`=1, `dirty`=0, tag=ADDRESS[7:5].
  - Go to IDLE. The original request then hits; a store performs its write on that hit cycle.
- `BUSYWAIT`=1 in WRITEBACK, FETCH, FILL, and in IDLE on miss. Otherwise 0.
- `READDATA`=0 unless a read hit is in IDLE.
- Memory handshake:
  - WRITEBACK and FETCH each last at least 2 cycles, because the entry cycle is never an exit.
  - Exit on the first later posedge where `MEM_BUSYWAIT`=0.
  - `MEM_READ`/`MEM_WRITE` drop to 0 in the cycle after exit. They are never high together.
- A request deasserted mid-miss does not abort: the FSM completes through FILL, and no store is performed.
- `RESET` low at any time: state goes to IDLE immediately. All `valid`/`dirty` bits clear. `MEM_READ`, `MEM_WRITE`, `BUSYWAIT` and `READDATA` are 0. Data and tag arrays are not cleared.
- `READ`&&`WRITE` together is illegal; treat it as `READ`.

## Timing
- Read hit: 0-cycle latency; data is valid in the request cycle.
- Write hit: 1 posedge.
- Clean miss, memory busy for N≥1 cycles after entry: FETCH takes N+1 cycles, plus 1 cycle FILL, plus 1 hit cycle.
- Dirty miss: adds the WRITEBACK duration (M+1 cycles).
- Reset outputs: `BUSYWAIT`=0, `READDATA`=0, `MEM_READ`=0, `MEM_WRITE`=0, `MEM_ADDRESS`=0, `MEM_WRITEDATA`=0.
- State and arrays update only on posedge `CLK` or negedge `RESET`.

## Structure
- Shared package `cache_pkg`:
  - FSM state encoding.
  - `TAG_W`=3, `IDX_W`=3, `OFF_W`=2.
  - Address-field slice constants.
- Sub-module `cache_store`:
  - Tag/valid/dirty/data arrays.
  - Combinational hit/readout.
  - Byte write and line fill ports.
- `data_cache` contains the FSM and the memory handshake.

## Test plan
- Reset, then `READ` at 0x25: miss; `MEM_READ`=1, `MEM_ADDRESS`=0x09. Memory returns 0x44332211 after 3 busy cycles. After FILL, `READDATA`=0x22 and `BUSYWAIT` falls.
- `WRITE` 0xAB at 0x26 after the fill: no memory traffic. `READ` 0x26 next cycle returns 0xAB.
- `READ` 0xA6 (same index 1, tag 5): `MEM_WRITE` first with `MEM_ADDRESS`=0x09, `MEM_WRITEDATA`=0x44AB2211. Then `MEM_READ` with `MEM_ADDRESS`=0x29. `MEM_READ`/`MEM_WRITE` are never high together.
- `MEM_BUSYWAIT` held 0 throughout: each memory state lasts exactly 2 cycles. Clean miss total `BUSYWAIT` = 4 cycles.
- `RESET` low during FETCH: `MEM_READ` drops immediately. A subsequent `READ` of the previously filled address misses, because valid was cleared.
- `READ` dropped during FETCH: FILL still completes. The next `READ` of that address hits with no memory access.
